airi5c_spi_tx_arbiter: RTL

Transmit-side scheduler for the AIRI5C SPI slave: shares the slave's single TX frame interface (data_in / tx_empty / pop) between NUM_REQ requester queues. Runs entirely in the slave's tx_rclk domain, so the frame source is chosen on the same edges the slave uses to load frames. Round-robin arbitration with per-grant burst locking: a winner keeps the grant for burst_len frames or until it runs empty.

---
 rtl/airi5c_spi_tx_arbiter_pkg.sv | 20 ++
 rtl/airi5c_spi_tx_arbiter_rr_pick.sv | 46 ++++
 rtl/airi5c_spi_tx_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/airi5c_spi_tx_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : airi5c_spi_tx_arbiter_pkg
// Brief  : Shared state encoding and index-width helper for the SPI TX arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package airi5c_spi_tx_arbiter_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_GRANT = 1'b1;

    function automatic int req_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/airi5c_spi_tx_arbiter_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : airi5c_rr_pick
// Brief  : Combinational rotate-priority picker; first set request at or after
//          the start pointer, wrapping modulo NUM_REQ.
// Rev    : 1.0 - initial release
// ============================================================================
module airi5c_rr_pick
    import airi5c_spi_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = req_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] w_pos [NUM_REQ];

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_pos
            logic [IDX_W:0] w_sum;
            assign w_sum    = {1'b0, start} + (IDX_W+1)'(k);
            assign w_pos[k] = (w_sum >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                            : w_sum[IDX_W-1:0];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[w_pos[k]]) begin
                found = 1'b1;
                index = w_pos[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/airi5c_spi_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : airi5c_spi_tx_arbiter
// Brief  : Round-robin, burst-locked sharing of the SPI slave TX frame port.
//          Optional urgent requester 0 with AIRI5C_SPI_TX_ARB_PRIO_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module airi5c_spi_tx_arbiter
    import airi5c_spi_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 4
) (
    input  logic                               tx_rclk,
    input  logic                               n_reset,
    input  logic                               enable,
    input  logic [BURST_WIDTH-1:0]             burst_len,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                 req_pop,
    input  logic                               slave_pop,
    output logic                               slave_tx_empty,
    output logic [DATA_WIDTH-1:0]              slave_data,
    output logic                               grant_valid,
    output logic [req_idx_width(NUM_REQ)-1:0]  grant_id
);

    localparam int IDX_W = req_idx_width(NUM_REQ);

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_grant_id;
    logic [BURST_WIDTH-1:0] r_remaining;
    logic [IDX_W-1:0]       r_rr_ptr;

    logic                   w_found;
    logic [IDX_W-1:0]       w_win;
    logic [IDX_W-1:0]       w_next_ptr;
    logic                   w_grant_valid;

    airi5c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .start (r_rr_ptr),
        .found (w_found),
        .index (w_win)
    );

    assign w_next_ptr    = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + IDX_W'(1);
    assign w_grant_valid = (r_state == ST_GRANT);

    assign grant_valid    = w_grant_valid;
    assign grant_id       = r_grant_id;
    assign slave_tx_empty = !w_grant_valid || !req_valid[r_grant_id];
    assign slave_data     = w_grant_valid
                          ? req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH]
                          : '0;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_pop
            assign req_pop[i] = slave_pop && w_grant_valid && (r_grant_id == IDX_W'(i));
        end
    endgenerate

    // r_remaining == 0 while granted means the grant was taken with burst_len 0.
    always_ff @(posedge tx_rclk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= '0;
            r_remaining <= '0;
            r_rr_ptr    <= '0;
        end else if (!enable) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef AIRI5C_SPI_TX_ARB_PRIO_EN
                    if (req_valid[0]) begin
                        r_state     <= ST_GRANT;
                        r_grant_id  <= '0;
                        r_remaining <= burst_len;
                    end else
`endif
                    if (w_found) begin
                        r_state     <= ST_GRANT;
                        r_grant_id  <= w_win;
                        r_remaining <= burst_len;
                        r_rr_ptr    <= w_next_ptr;
                    end
                end
                ST_GRANT: begin
                    if (slave_pop) begin
`ifdef AIRI5C_SPI_TX_ARB_PRIO_EN
                        if ((r_grant_id != '0) && req_valid[0]) begin
                            r_state     <= ST_IDLE;
                            r_remaining <= '0;
                        end else
`endif
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - BURST_WIDTH'(1);
                            if (r_remaining == BURST_WIDTH'(1)) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else if (!req_valid[r_grant_id]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
